// File: rtl/proc_front_panel.sv
// Board front-end for the simple processor: debounced buttons, DIN assembly,
// Run generation (level or single-step), Done capture and 7-segment display.

module proc_front_panel_btn #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic          block;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            block   <= 1'b1;
            vld     <= 2'b00;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            vld     <= {vld[0], 1'b1};
            level_d <= level;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            // A button held through reset stays blocked until seen released
            if (vld[1] && !sync2 && !level)
                block <= 1'b0;
            pulse <= level & ~level_d & ~block;
        end
    end
endmodule

module proc_front_panel #(
    parameter int DATA_W          = 16,
    parameter int CHUNK_W         = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 16,
    localparam int NUM_CHUNKS     = DATA_W / CHUNK_W,
    localparam int SEL_W          = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int NUM_DIGITS     = DATA_W / 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [CHUNK_W-1:0]      Sw_data,
    input  logic [SEL_W-1:0]        Chunk_sel,
    input  logic                    Load_btn,
    input  logic                    Step_btn,
    input  logic                    Mode,
    input  logic                    Run_sw,
    input  logic [1:0]              Disp_sel,
    input  logic [DATA_W-1:0]       BusWires,
    input  logic                    Done,
    output logic [DATA_W-1:0]       DIN,
    output logic                    Run,
    output logic                    Busy,
    output logic [COUNT_W-1:0]      Instr_count,
    output logic [7*NUM_DIGITS-1:0] Hex
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    state_t              state_nx;
    logic                load_pulse;
    logic                step_pulse;
    logic                done_d;
    logic                done_rise;
    logic                abort;
    logic                skip;
    logic [DATA_W-1:0]   cap;
    logic [DATA_W-1:0]   src;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        unique case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            4'hF: seg7 = 7'b0001110;
        endcase
    endfunction

    proc_front_panel_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load (
        .Clock(Clock),
        .Reset(Reset),
        .raw  (Load_btn),
        .pulse(load_pulse)
    );

    proc_front_panel_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .Clock(Clock),
        .Reset(Reset),
        .raw  (Step_btn),
        .pulse(step_pulse)
    );

    assign done_rise = Done & ~done_d;
    assign abort     = (state == ACTIVE) && !Mode;
    assign Busy      = (state == ACTIVE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (Mode && step_pulse)
                    state_nx = ACTIVE;
            ACTIVE:
                if (!Mode || Done)
                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            Run   <= 1'b0;
        end else begin
            state <= state_nx;
            Run   <= Mode ? (state_nx == ACTIVE) : Run_sw;
        end
    end

    // An instruction aborted by leaving step mode is not counted
    always_ff @(posedge Clock) begin
        if (Reset) begin
            done_d      <= 1'b0;
            skip        <= 1'b0;
            cap         <= '0;
            Instr_count <= '0;
        end else begin
            done_d <= Done;
            if (done_rise)
                cap <= BusWires;
            if (done_rise && !skip && !abort && (Instr_count != '1))
                Instr_count <= Instr_count + 1'b1;
            if (abort)
                skip <= 1'b1;
            else if (done_rise)
                skip <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            DIN <= '0;
        end else if (load_pulse) begin
            for (int c = 0; c < NUM_CHUNKS; c++)
                if (Chunk_sel == SEL_W'(c))
                    DIN[c*CHUNK_W +: CHUNK_W] <= Sw_data;
        end
    end

    always_comb begin
        src = BusWires;
        unique case (Disp_sel)
            2'd0: src = BusWires;
            2'd1: src = cap;
            2'd2: src = DIN;
            2'd3: src = DATA_W'(Instr_count);
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                Hex[7*i +: 7] <= 7'b1000000;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
                Hex[7*i +: 7] <= seg7(src[4*i +: 4]);
        end
    end
endmodule

// File: tb/tb_proc_front_panel.sv
// Directed bench for proc_front_panel: default 16-bit build plus a
// 24-bit / 4-bit-counter build for chunk range and saturation.

module tb_proc_front_panel;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw_data;
    logic [0:0]  chunk_sel;
    logic        load_btn;
    logic        step_btn;
    logic        mode;
    logic        run_sw;
    logic [1:0]  disp_sel;
    logic [15:0] bus;
    logic        done;
    logic [15:0] din;
    logic        run;
    logic        busy;
    logic [15:0] icount;
    logic [27:0] hex;

    logic [1:0]  chunk_sel2;
    logic [23:0] bus2;
    logic        done2;
    logic [23:0] din2;
    logic        run2;
    logic        busy2;
    logic [3:0]  icount2;
    logic [41:0] hex2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    proc_front_panel dut (
        .Clock      (clk),
        .Reset      (rst),
        .Sw_data    (sw_data),
        .Chunk_sel  (chunk_sel),
        .Load_btn   (load_btn),
        .Step_btn   (step_btn),
        .Mode       (mode),
        .Run_sw     (run_sw),
        .Disp_sel   (disp_sel),
        .BusWires   (bus),
        .Done       (done),
        .DIN        (din),
        .Run        (run),
        .Busy       (busy),
        .Instr_count(icount),
        .Hex        (hex)
    );

    proc_front_panel #(
        .DATA_W (24),
        .COUNT_W(4)
    ) dut2 (
        .Clock      (clk),
        .Reset      (rst),
        .Sw_data    (sw_data),
        .Chunk_sel  (chunk_sel2),
        .Load_btn   (load_btn),
        .Step_btn   (step_btn),
        .Mode       (mode),
        .Run_sw     (run_sw),
        .Disp_sel   (disp_sel),
        .BusWires   (bus2),
        .Done       (done2),
        .DIN        (din2),
        .Run        (run2),
        .Busy       (busy2),
        .Instr_count(icount2),
        .Hex        (hex2)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_load();
        load_btn = 1'b1;
        tick(10);
        load_btn = 1'b0;
        tick(10);
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if (din !== 16'h0 || run !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl din=%h run=%b busy=%b exp 0", din, run, busy);
        end
        checks++;
        if (icount !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got=%h exp=0000", icount);
        end
        checks++;
        if (hex !== {4{7'b1000000}}) begin
            errors++;
            $display("FAIL reset_hex got=%h exp=%h", hex, {4{7'b1000000}});
        end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_din_load();
        logic [27:0] exp;
        chunk_sel = 1'b0;
        sw_data   = 8'h34;
        press_load();
        chunk_sel = 1'b1;
        sw_data   = 8'h12;
        press_load();
        checks++;
        if (din !== 16'h1234) begin
            errors++;
            $display("FAIL din_load got=%h exp=1234", din);
        end
        disp_sel = 2'd2;
        tick();
        exp = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        checks++;
        if (hex !== exp) begin
            errors++;
            $display("FAIL hex_din got=%h exp=%h", hex, exp);
        end
    endtask

    task automatic test_debounce();
        chunk_sel = 1'b0;
        sw_data   = 8'hFF;
        load_btn  = 1'b1;
        tick(3);
        load_btn = 1'b0;
        tick(12);
        checks++;
        if (din !== 16'h1234) begin
            errors++;
            $display("FAIL glitch got=%h exp=1234", din);
        end
        sw_data  = 8'h56;
        load_btn = 1'b1;
        tick(7);
        checks++;
        if (din !== 16'h1234) begin
            errors++;
            $display("FAIL early_write got=%h exp=1234", din);
        end
        tick();
        checks++;
        if (din !== 16'h1256) begin
            errors++;
            $display("FAIL pulse_time got=%h exp=1256", din);
        end
        sw_data = 8'h99;
        tick(2);
        load_btn = 1'b0;
        tick(10);
        checks++;
        if (din !== 16'h1256) begin
            errors++;
            $display("FAIL one_write got=%h exp=1256", din);
        end
    endtask

    task automatic test_step();
        logic [27:0] exp;
        do_reset();
        mode = 1'b1;
        done = 1'b0;
        press_step();
        checks++;
        if (run !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL step_go run=%b busy=%b exp 1 1", run, busy);
        end
        tick(5);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL step_hold run=%b exp=1", run);
        end
        press_step();
        checks++;
        if (busy !== 1'b1 || icount !== 16'd0) begin
            errors++;
            $display("FAIL step_ignore busy=%b cnt=%h exp 1 0", busy, icount);
        end
        bus  = 16'hBEEF;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (run !== 1'b0 || busy !== 1'b0 || icount !== 16'd1) begin
            errors++;
            $display("FAIL step_done run=%b busy=%b cnt=%h exp 0 0 1",
                     run, busy, icount);
        end
        disp_sel = 2'd1;
        bus      = 16'h0000;
        tick();
        exp = {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
        checks++;
        if (hex !== exp) begin
            errors++;
            $display("FAIL hex_cap got=%h exp=%h", hex, exp);
        end
    endtask

    task automatic test_level();
        mode   = 1'b0;
        run_sw = 1'b1;
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL level_delay run=%b exp=0", run);
        end
        tick();
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL level_on run=%b exp=1", run);
        end
        run_sw = 1'b0;
        tick();
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL level_off run=%b exp=0", run);
        end
        done = 1'b1;
        tick();
        checks++;
        if (icount !== 16'd2) begin
            errors++;
            $display("FAIL done_edge got=%h exp=0002", icount);
        end
        tick(5);
        done = 1'b0;
        tick();
        checks++;
        if (icount !== 16'd2) begin
            errors++;
            $display("FAIL done_once got=%h exp=0002", icount);
        end
    endtask

    task automatic test_reset_active();
        logic [27:0] exp;
        do_reset();
        mode      = 1'b1;
        chunk_sel = 1'b0;
        sw_data   = 8'hCD;
        press_load();
        chunk_sel = 1'b1;
        sw_data   = 8'hAB;
        press_load();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (icount !== 16'd1) begin
            errors++;
            $display("FAIL idle_count got=%h exp=0001", icount);
        end
        press_step();
        disp_sel = 2'd2;
        tick();
        exp = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
        checks++;
        if (run !== 1'b1 || busy !== 1'b1 || hex !== exp) begin
            errors++;
            $display("FAIL pre_rst run=%b busy=%b hex=%h exp 1 1 %h",
                     run, busy, hex, exp);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (run !== 1'b0 || busy !== 1'b0 || din !== 16'h0) begin
            errors++;
            $display("FAIL rst_act run=%b busy=%b din=%h exp 0 0 0000",
                     run, busy, din);
        end
        checks++;
        if (icount !== 16'd0 || hex !== {4{7'b1000000}}) begin
            errors++;
            $display("FAIL rst_act2 cnt=%h hex=%h exp 0000 %h",
                     icount, hex, {4{7'b1000000}});
        end
        rst  = 1'b0;
        mode = 1'b0;
        tick(3);
    endtask

    task automatic test_held_reset();
        chunk_sel = 1'b0;
        sw_data   = 8'h77;
        load_btn  = 1'b1;
        rst       = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(15);
        checks++;
        if (din !== 16'h0) begin
            errors++;
            $display("FAIL held_btn got=%h exp=0000", din);
        end
        load_btn = 1'b0;
        tick(10);
        press_load();
        checks++;
        if (din !== 16'h0077) begin
            errors++;
            $display("FAIL repress got=%h exp=0077", din);
        end
    endtask

    task automatic test_wide_cfg();
        do_reset();
        chunk_sel2 = 2'd2;
        sw_data    = 8'hAB;
        press_load();
        checks++;
        if (din2 !== 24'hAB0000) begin
            errors++;
            $display("FAIL chunk_hi got=%h exp=ab0000", din2);
        end
        chunk_sel2 = 2'd3;
        sw_data    = 8'h55;
        press_load();
        checks++;
        if (din2 !== 24'hAB0000) begin
            errors++;
            $display("FAIL chunk_oor got=%h exp=ab0000", din2);
        end
        repeat (14) begin
            done2 = 1'b1;
            tick();
            done2 = 1'b0;
            tick();
        end
        checks++;
        if (icount2 !== 4'hE) begin
            errors++;
            $display("FAIL cnt14 got=%h exp=e", icount2);
        end
        repeat (3) begin
            done2 = 1'b1;
            tick();
            done2 = 1'b0;
            tick();
        end
        checks++;
        if (icount2 !== 4'hF) begin
            errors++;
            $display("FAIL saturate got=%h exp=f", icount2);
        end
    endtask

    initial begin
        rst        = 1'b1;
        sw_data    = 8'h00;
        chunk_sel  = 1'b0;
        load_btn   = 1'b0;
        step_btn   = 1'b0;
        mode       = 1'b0;
        run_sw     = 1'b0;
        disp_sel   = 2'd0;
        bus        = 16'h0;
        done       = 1'b0;
        chunk_sel2 = 2'd0;
        bus2       = 24'h0;
        done2      = 1'b0;
        test_reset();
        test_din_load();
        test_debounce();
        test_step();
        test_level();
        test_reset_active();
        test_held_reset();
        test_wide_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proc_front_panel.md
Name: proc_front_panel

Overview:
- Parametrised board front-end for the simple processor. Replaces ad-hoc switch/key glue with registered logic.
- Assembles the DIN word from switch chunks on debounced Load presses.
- Generates Run in level or single-step handshake mode and counts completed instructions.
- Captures the bus at Done and drives a registered multi-digit 7-segment display from a selectable source.

Parameters:
- DATA_W, 16, processor word width; must be a multiple of CHUNK_W and of 4.
- CHUNK_W, 8, switch chunk width loaded per Load press.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=1).
- COUNT_W, 16, instruction counter width (<= DATA_W).
- Derived: NUM_CHUNKS = DATA_W/CHUNK_W; SEL_W = max(1, clog2(NUM_CHUNKS)); NUM_DIGITS = DATA_W/4.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Sw_data  in  CHUNK_W  chunk value to load.
- Chunk_sel  in  SEL_W  DIN chunk index (0 = least significant).
- Load_btn  in  1  raw asynchronous button, active-high.
- Step_btn  in  1  raw asynchronous button, active-high.
- Mode  in  1  0 = level Run, 1 = single-step handshake.
- Run_sw  in  1  Run request used in level mode.
- Disp_sel  in  2  display source select.
- BusWires  in  DATA_W  processor bus.
- Done  in  1  processor instruction-complete.
- DIN  out  DATA_W  assembled instruction/data word.
- Run  out  1  processor Run.
- Busy  out  1  high while the step FSM is in ACTIVE.
- Instr_count  out  COUNT_W  completed-instruction counter.
- Hex  out  7*NUM_DIGITS  active-low segments; digit i occupies [7i+6:7i], bit 0 = seg a … bit 6 = seg g.

Behaviour:
- Reset values: DIN=0, Run=0, Busy=0, Instr_count=0, capture register=0, debounced levels=0, every Hex digit=7'b1000000 ("0").
- Button path (Load and Step independently):
  - 2-flop synchroniser, then debounce counter; the debounced level flips only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
  - Each button produces a 1-cycle pulse on the cycle after its debounced level rises.
  - Total latency from first rising edge sampling raw=1 to the pulse being high: 3+DEBOUNCE_CYCLES cycles. Falling edges produce no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- DIN load:
  - On a Load pulse, DIN[Chunk_sel*CHUNK_W +: CHUNK_W] <= Sw_data; other bits hold.
  - Chunk_sel >= NUM_CHUNKS: pulse ignored, DIN unchanged.
  - DIN is fully registered; no latches.
- Level mode (Mode=0): Run <= Run_sw (1-cycle register); FSM held in IDLE; Busy=0.
- Step mode (Mode=1), FSM states IDLE and ACTIVE:
  - IDLE: Run=0. Step pulse -> ACTIVE.
  - ACTIVE: Run=1, Busy=1. Done=1 sampled -> IDLE (Run falls the next cycle).
  - Step pulses while ACTIVE are ignored.
  - A Mode change to 0 while ACTIVE forces IDLE next cycle and disables counting for that instruction.
- Done handling (both modes): detect the rising edge of Done (registered previous value).
  - On that edge: capture register <= BusWires; Instr_count increments.
  - Instr_count saturates at all-ones; no wrap.
  - Done held high for several cycles counts once.
  - Done rising in the same cycle as a Step pulse in IDLE: both act (count and enter ACTIVE).
- Display source by Disp_sel: 0 live BusWires, 1 capture register, 2 DIN, 3 Instr_count zero-extended to DATA_W.
  - Hex is registered: 1-cycle latency from source change to segment change.
  - Digit i shows nibble [4i+3:4i].
- Segment patterns (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted mid-operation (e.g. in ACTIVE, or mid-debounce): all state returns to reset values on the next edge; a button held through reset must be released and pressed again to produce a pulse.

Test Plan:
- Reset, then Load pulse with Chunk_sel=0, Sw_data=8'h34; Load pulse with Chunk_sel=1, Sw_data=8'h12 -> DIN=16'h1234. Disp_sel=2 -> Hex digits from 0 upward = 4,3,2,1 (0011001, 0110000, 0100100, 1111001) one cycle later.
- DEBOUNCE_CYCLES=4: raw Load high for 3 cycles -> no pulse, DIN unchanged. Held for 10 cycles -> exactly one write, pulse at cycle 7 after first sample.
- Mode=1: Step pulse -> Run=1, Busy=1. Hold Done=0 for 5 cycles, Run stays 1. Pulse Done=1 with BusWires=16'hBEEF -> Run=0 next cycle, Instr_count=1, Disp_sel=1 shows F,E,E,b. Second Step during ACTIVE ignored.
- Mode=0: Run follows Run_sw with 1-cycle delay. Done held high 6 cycles -> Instr_count increments by exactly 1.
- COUNT_W=4: 17 Done edges -> Instr_count=4'hF (saturated). Chunk_sel out of range (NUM_CHUNKS=3 config) -> DIN unchanged.
- Reset asserted while ACTIVE with DIN=16'hABCD -> next cycle Run=0, Busy=0, DIN=0, Instr_count=0, all Hex=1000000.
